exc_ctrl: RTL and testbench
===========================

// Module: exc_ctrl
// PURPOSE
// - MEM-stage exception arbiter; sits directly upstream of the CP0 register file.
// - Merges per-instruction exception flags with pending interrupts, resolving priority and CP0 write hazards.
// - Drives the CP0 except_type/pc/delayslot inputs, and the pipeline flush plus redirect PC to fetch.
// PARAMETERS
// - EXC_VECTOR    32'hBFC00380  general exception entry PC
// - FLUSH_CYCLES  2             cycles flush_o stays high per taken event (>=1)
// PORTS
// - clk                 in   1   clock
// - rst                 in   1   reset; asynchronous, active-high
// - mem_valid_i         in   1   MEM slot holds a real instruction
// - mem_pc_i            in   32  PC of MEM instruction
// - mem_delayslot_i     in   1   MEM instruction is in a delay slot
// - exc_ri_i            in   1   reserved instruction
// - exc_sys_i           in   1   syscall
// - exc_brk_i           in   1   break
// - exc_ov_i            in   1   overflow
// - exc_trap_i          in   1   trap
// - exc_eret_i          in   1   eret
// - cp0_status_i        in   32  current Status
// - cp0_cause_i         in   32  current Cause
// - cp0_epc_i           in   32  current EPC
// - wb_cp0_we_i         in   1   in-flight mtc0 (WB)
// - wb_cp0_waddr_i      in   5   mtc0 target register
// - wb_cp0_wdata_i      in   32  mtc0 data
// - except_type_o       out  32  to CP0: 0 none, 1 int, 8 sys, 9 brk, a ri, c ov, d trap, e eret
// - except_pc_o         out  32  to CP0: mem_pc_i passthrough
// - except_delayslot_o  out  1   to CP0: mem_delayslot_i passthrough
// - flush_o             out  1   flush IF..MEM
// - new_pc_o            out  32  redirect target, valid while flush_o
// BEHAVIOUR
// - Reset: flush_o=0, new_pc_o=0, FSM=IDLE, counter=0; except_type_o=0 while rst high.
// - Forwarding: effective Status/Cause/EPC = WB mtc0 data when wb_cp0_we_i and address matches (12/13/14), else CP0 input.
//   - Cause forwarding replaces bits [9:8] only; bits [15:10] always come from cp0_cause_i.
// - int_pend = eff_status[0] & ~eff_status[1] & |(eff_cause[15:8] & eff_status[15:8]).
// - except_type_o is combinational, same cycle. Nonzero only when FSM==IDLE and mem_valid_i.
// - Priority, high to low: int > ri > sys > brk > ov > trap > eret.
//   - Exactly one code is emitted; simultaneous flags resolve by this order.
// - FSM IDLE -> FLUSH on any nonzero except_type_o.
//   - Counter loads FLUSH_CYCLES-1.
//   - Next edge: flush_o=1; new_pc_o = eff EPC (eret) or EXC_VECTOR (all other codes), latched at the taking edge.
// - FLUSH: counter decrements each cycle; flush_o held high, new_pc_o held.
//   - At counter==0, returns to IDLE next edge; flush_o=0 and new_pc_o holds its value.
//   - All exceptions masked while in FLUSH; flush squashes the instruction anyway.
// - Masking applies to the ENTIRE FLUSH window, including the cycle in which a new MEM instruction appears.
// - mem_valid_i=0 (bubble): no exception and no interrupt taken; interrupt stays pending until next valid instr.
// - rst mid-FLUSH: immediate return to IDLE, outputs go to reset values asynchronously.
// CONFIGURATION
// - Macro EXC_ADDR_ERR_EN adds the following when defined:
//   - Inputs exc_adel_if_i, exc_adel_i, exc_ades_i (1b) and bad_addr_i (32).
//   - Output bad_vaddr_o (32): mem_pc_i for fetch AdEL, else bad_addr_i; 0 when none.
//   - Codes 4 (AdEL) and 5 (AdES); priority int > adel_if > ri > sys > brk > ov > trap > adel > ades > eret.
// - Macro undefined: those ports and codes do not exist.
// STRUCTURE
// - Shared package (cpu_pkg): exception code localparams (EXC_NONE, EXC_INT ... EXC_ERET, EXC_ADEL, EXC_ADES).
// - Shared package (cpu_pkg): CP0 register address constants and the typedef enum {IDLE, FLUSH} exc_state_t.
// - One sub-module: exc_prio_enc (flag vector -> 32b code, pure combinational priority encoder).
// TESTING
// - Bench parameters: FLUSH_CYCLES=2, EXC_VECTOR=32'hBFC00380 (the defaults).
// - 1. Syscall: sys=1, pc=0x80001000, valid -> except_type=8 same cycle.
//   - flush_o=1 for 2 cycles from next edge; new_pc=0xBFC00380.
// - 2. Priority: ri, sys and ov all set -> except_type=0xa only.
// - 3. Interrupt: status=0x0000_0401, cause[10]=1, valid -> type=1.
//   - Same with status[1]=1 (EXL) -> type=0.
//   - Same with wb mtc0 Status=0 in flight -> type=0 (forwarding).
// - 4. Eret forwarding: epc=0x100 while WB writes EPC=0x200 -> type=0xe, new_pc=0x200.
// - 5. Masking: second sys during FLUSH window -> type=0, flush not extended.
//   - Bubble with pending int -> type=0 until the next valid instruction.
// - 6. Async reset asserted mid-FLUSH -> flush_o=0, new_pc_o=0 without a clock edge.
//   - With EXC_ADDR_ERR_EN: adel_if=1, pc=0x80000003 -> type=4, bad_vaddr=0x80000003.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - exception codes, CP0 addresses and shared types for the MEM-stage exception arbiter
package cpu_pkg;

  localparam logic [31:0] EXC_NONE = 32'h0;
  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_ADEL = 32'h4;
  localparam logic [31:0] EXC_ADES = 32'h5;
  localparam logic [31:0] EXC_SYS  = 32'h8;
  localparam logic [31:0] EXC_BRK  = 32'h9;
  localparam logic [31:0] EXC_RI   = 32'hA;
  localparam logic [31:0] EXC_OV   = 32'hC;
  localparam logic [31:0] EXC_TRAP = 32'hD;
  localparam logic [31:0] EXC_ERET = 32'hE;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  typedef enum logic {IDLE, FLUSH} exc_state_t;

  typedef struct packed {
    logic intr;
`ifdef EXC_ADDR_ERR_EN
    logic adel_if;
    logic adel;
    logic ades;
`endif
    logic ri;
    logic sys;
    logic brk;
    logic ov;
    logic trap;
    logic eret;
  } exc_flags_t;

endpackage

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - fixed-priority exception flag encoder to 32-bit CP0 except_type code
module exc_prio_enc
  import cpu_pkg::*;
(
  input  exc_flags_t  flags_i,
  output logic [31:0] code_o
);

  // Lowest priority assigned first so each higher-priority flag overrides.
  always_comb begin
    code_o = EXC_NONE;
    if (flags_i.eret) code_o = EXC_ERET;
`ifdef EXC_ADDR_ERR_EN
    if (flags_i.ades) code_o = EXC_ADES;
    if (flags_i.adel) code_o = EXC_ADEL;
`endif
    if (flags_i.trap) code_o = EXC_TRAP;
    if (flags_i.ov)   code_o = EXC_OV;
    if (flags_i.brk)  code_o = EXC_BRK;
    if (flags_i.sys)  code_o = EXC_SYS;
    if (flags_i.ri)   code_o = EXC_RI;
`ifdef EXC_ADDR_ERR_EN
    if (flags_i.adel_if) code_o = EXC_ADEL;
`endif
    if (flags_i.intr) code_o = EXC_INT;
  end

endmodule

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - MEM-stage exception/interrupt arbiter driving CP0 and pipeline flush
// Optional address-error exceptions (AdEL/AdES, bad_vaddr_o) enabled by EXC_ADDR_ERR_EN.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_delayslot_i,
  input  logic        exc_ri_i,
  input  logic        exc_sys_i,
  input  logic        exc_brk_i,
  input  logic        exc_ov_i,
  input  logic        exc_trap_i,
  input  logic        exc_eret_i,
`ifdef EXC_ADDR_ERR_EN
  input  logic        exc_adel_if_i,
  input  logic        exc_adel_i,
  input  logic        exc_ades_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] bad_vaddr_o,
`endif
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  output logic [31:0] except_type_o,
  output logic [31:0] except_pc_o,
  output logic        except_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);
  import cpu_pkg::*;

  localparam int unsigned    CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  exc_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             flush_q;
  logic [31:0]      new_pc_q;

  logic        fwd_status, fwd_cause, fwd_epc;
  logic [15:0] eff_status;
  logic [15:8] eff_ip;
  logic [31:0] eff_epc;
  logic        int_pend;
  exc_flags_t  flags;
  logic [31:0] enc_code;
  logic        unused_bits;

  assign fwd_status = wb_cp0_we_i && (wb_cp0_waddr_i == CP0_REG_STATUS);
  assign fwd_cause  = wb_cp0_we_i && (wb_cp0_waddr_i == CP0_REG_CAUSE);
  assign fwd_epc    = wb_cp0_we_i && (wb_cp0_waddr_i == CP0_REG_EPC);

  // mtc0 to Cause only reaches the software interrupt bits; hardware lines stay live.
  assign eff_status = fwd_status ? wb_cp0_wdata_i[15:0] : cp0_status_i[15:0];
  assign eff_ip     = {cp0_cause_i[15:10], fwd_cause ? wb_cp0_wdata_i[9:8] : cp0_cause_i[9:8]};
  assign eff_epc    = fwd_epc ? wb_cp0_wdata_i : cp0_epc_i;

  assign int_pend = eff_status[0] & ~eff_status[1] & (|(eff_ip & eff_status[15:8]));

  assign unused_bits = ^{cp0_status_i[31:16], cp0_cause_i[31:16], cp0_cause_i[7:0], eff_status[7:2]};

  always_comb begin
    flags      = '0;
    flags.intr = int_pend;
    flags.ri   = exc_ri_i;
    flags.sys  = exc_sys_i;
    flags.brk  = exc_brk_i;
    flags.ov   = exc_ov_i;
    flags.trap = exc_trap_i;
    flags.eret = exc_eret_i;
`ifdef EXC_ADDR_ERR_EN
    flags.adel_if = exc_adel_if_i;
    flags.adel    = exc_adel_i;
    flags.ades    = exc_ades_i;
`endif
  end

  exc_prio_enc u_prio_enc (
    .flags_i (flags),
    .code_o  (enc_code)
  );

  assign except_type_o      = (!rst && state_q == IDLE && mem_valid_i) ? enc_code : EXC_NONE;
  assign except_pc_o        = mem_pc_i;
  assign except_delayslot_o = mem_delayslot_i;
  assign flush_o            = flush_q;
  assign new_pc_o           = new_pc_q;

`ifdef EXC_ADDR_ERR_EN
  always_comb begin
    bad_vaddr_o = '0;
    if (except_type_o == EXC_ADEL)
      bad_vaddr_o = exc_adel_if_i ? mem_pc_i : bad_addr_i;
    else if (except_type_o == EXC_ADES)
      bad_vaddr_o = bad_addr_i;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (except_type_o != EXC_NONE) begin
            state_q  <= FLUSH;
            cnt_q    <= CNT_LOAD;
            flush_q  <= 1'b1;
            new_pc_q <= (except_type_o == EXC_ERET) ? eff_epc : EXC_VECTOR;
          end
        end
        FLUSH: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - scoreboard bench for exc_ctrl (FLUSH_CYCLES=2, EXC_VECTOR=BFC00380)
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_delayslot;
  logic [31:0] mem_pc;
  logic        ri, sys, brk, ov, trap, eret;
  logic [31:0] status, cause, epc;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic [31:0] except_type, except_pc, new_pc;
  logic        except_ds, flush;
`ifdef EXC_ADDR_ERR_EN
  logic        adel_if, adel, ades;
  logic [31:0] bad_addr, bad_vaddr;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  exc_ctrl #(.EXC_VECTOR(32'hBFC00380), .FLUSH_CYCLES(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .mem_valid_i        (mem_valid),
    .mem_pc_i           (mem_pc),
    .mem_delayslot_i    (mem_delayslot),
    .exc_ri_i           (ri),
    .exc_sys_i          (sys),
    .exc_brk_i          (brk),
    .exc_ov_i           (ov),
    .exc_trap_i         (trap),
    .exc_eret_i         (eret),
`ifdef EXC_ADDR_ERR_EN
    .exc_adel_if_i      (adel_if),
    .exc_adel_i         (adel),
    .exc_ades_i         (ades),
    .bad_addr_i         (bad_addr),
    .bad_vaddr_o        (bad_vaddr),
`endif
    .cp0_status_i       (status),
    .cp0_cause_i        (cause),
    .cp0_epc_i          (epc),
    .wb_cp0_we_i        (wb_we),
    .wb_cp0_waddr_i     (wb_waddr),
    .wb_cp0_wdata_i     (wb_wdata),
    .except_type_o      (except_type),
    .except_pc_o        (except_pc),
    .except_delayslot_o (except_ds),
    .flush_o            (flush),
    .new_pc_o           (new_pc)
  );

  localparam int S_TYPE = 0, S_FLUSH = 1, S_NPC = 2, S_EPC = 3, S_DS = 4, S_BAD = 5;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_TYPE:  return except_type;
      S_FLUSH: return {31'b0, flush};
      S_NPC:   return new_pc;
      S_EPC:   return except_pc;
      S_DS:    return {31'b0, except_ds};
`ifdef EXC_ADDR_ERR_EN
      S_BAD:   return bad_vaddr;
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_out(input string tag, input int sel, input logic [31:0] v);
    sb_q.push_back('{tag, sel, v});
  endtask

  task automatic check_sb();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_sb();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    mem_valid = 0; mem_delayslot = 0; mem_pc = 32'h8000_0000;
    ri = 0; sys = 0; brk = 0; ov = 0; trap = 0; eret = 0;
    status = 0; cause = 0; epc = 0;
    wb_we = 0; wb_waddr = 0; wb_wdata = 0;
`ifdef EXC_ADDR_ERR_EN
    adel_if = 0; adel = 0; ades = 0; bad_addr = 0;
`endif
  endtask

  // Lets a taken event's 2-cycle flush window expire.
  task automatic drain();
    clear_in();
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1;
    clear_in();
    mem_valid = 1; sys = 1;
    expect_out("rst_type", S_TYPE, 32'h0);
    expect_out("rst_flush", S_FLUSH, 32'h0);
    expect_out("rst_newpc", S_NPC, 32'h0);
    tick();
    rst = 0;

    // Syscall, then masked second syscall inside the flush window
    clear_in();
    mem_valid = 1; mem_pc = 32'h8000_1000; mem_delayslot = 1; sys = 1;
    expect_out("sys_type", S_TYPE, 32'h8);
    expect_out("sys_epc", S_EPC, 32'h8000_1000);
    expect_out("sys_ds", S_DS, 32'h1);
    expect_out("sys_flush_pre", S_FLUSH, 32'h0);
    tick();
    expect_out("mask_type0", S_TYPE, 32'h0);
    expect_out("sys_flush0", S_FLUSH, 32'h1);
    expect_out("sys_newpc", S_NPC, 32'hBFC0_0380);
    tick();
    expect_out("mask_type1", S_TYPE, 32'h0);
    expect_out("sys_flush1", S_FLUSH, 32'h1);
    tick();
    mem_valid = 0;
    expect_out("flush_end", S_FLUSH, 32'h0);
    expect_out("newpc_hold", S_NPC, 32'hBFC0_0380);
    expect_out("bubble_type", S_TYPE, 32'h0);
    tick();

    // Priority
    clear_in(); mem_valid = 1; ri = 1; sys = 1; ov = 1;
    expect_out("prio_ri", S_TYPE, 32'hA);
    tick(); drain();
    clear_in(); mem_valid = 1; brk = 1; ov = 1; trap = 1; eret = 1;
    expect_out("prio_brk", S_TYPE, 32'h9);
    tick(); drain();
    clear_in(); mem_valid = 1; trap = 1; eret = 1;
    expect_out("prio_trap", S_TYPE, 32'hD);
    tick(); drain();
    clear_in(); mem_valid = 1; ri = 1; status = 32'h401; cause = 32'h400;
    expect_out("prio_int", S_TYPE, 32'h1);
    tick(); drain();

    // Interrupt enable, EXL and forwarding
    clear_in(); mem_valid = 1; status = 32'h403; cause = 32'h400;
    expect_out("int_exl", S_TYPE, 32'h0);
    tick();
    clear_in(); mem_valid = 1; status = 32'h401; cause = 32'h400;
    wb_we = 1; wb_waddr = 5'd12; wb_wdata = 32'h0;
    expect_out("int_fwd_status", S_TYPE, 32'h0);
    expect_out("int_fwd_noflush", S_FLUSH, 32'h0);
    tick();
    clear_in(); mem_valid = 1; status = 32'h101;
    wb_we = 1; wb_waddr = 5'd13; wb_wdata = 32'h100;
    expect_out("int_fwd_cause_sw", S_TYPE, 32'h1);
    tick(); drain();
    clear_in(); mem_valid = 1; status = 32'h401;
    wb_we = 1; wb_waddr = 5'd13; wb_wdata = 32'h400;
    expect_out("int_fwd_cause_hw", S_TYPE, 32'h0);
    tick();

    // Eret with EPC forwarded from WB
    clear_in(); mem_valid = 1; eret = 1; epc = 32'h100;
    wb_we = 1; wb_waddr = 5'd14; wb_wdata = 32'h200;
    expect_out("eret_type", S_TYPE, 32'hE);
    tick();
    clear_in();
    expect_out("eret_flush", S_FLUSH, 32'h1);
    expect_out("eret_newpc", S_NPC, 32'h200);
    tick();
    tick();

    // Bubble holds a pending interrupt until a valid instruction
    clear_in(); status = 32'h401; cause = 32'h400;
    expect_out("bubble_int0", S_TYPE, 32'h0);
    tick();
    expect_out("bubble_int1", S_TYPE, 32'h0);
    expect_out("bubble_noflush", S_FLUSH, 32'h0);
    tick();
    mem_valid = 1;
    expect_out("bubble_int_taken", S_TYPE, 32'h1);
    tick(); drain();

    // Asynchronous reset mid-flush
    clear_in(); mem_valid = 1; sys = 1;
    expect_out("arst_take", S_TYPE, 32'h8);
    tick();
    clear_in();
    expect_out("arst_pre_flush", S_FLUSH, 32'h1);
    check_sb();
    #2 rst = 1;
    #1;
    expect_out("arst_flush", S_FLUSH, 32'h0);
    expect_out("arst_newpc", S_NPC, 32'h0);
    check_sb();
    tick();
    rst = 0;
    clear_in(); mem_valid = 1; sys = 1;
    expect_out("arst_idle_type", S_TYPE, 32'h8);
    expect_out("arst_idle_flush", S_FLUSH, 32'h0);
    tick(); drain();

`ifdef EXC_ADDR_ERR_EN
    clear_in(); mem_valid = 1; mem_pc = 32'h8000_0003; adel_if = 1; bad_addr = 32'h1234;
    expect_out("adel_if_type", S_TYPE, 32'h4);
    expect_out("adel_if_bad", S_BAD, 32'h8000_0003);
    tick(); drain();
    clear_in(); mem_valid = 1; ades = 1; bad_addr = 32'h1234;
    expect_out("ades_type", S_TYPE, 32'h5);
    expect_out("ades_bad", S_BAD, 32'h1234);
    tick(); drain();
    clear_in(); mem_valid = 1; ades = 1; ov = 1; bad_addr = 32'h1234;
    expect_out("ov_over_ades", S_TYPE, 32'hC);
    expect_out("ov_bad", S_BAD, 32'h0);
    tick(); drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
